// File: rtl/clk_div_prog.sv
//----------------------------------------------------------------------------
// clk_div_prog
//
// Runtime-programmable integer clock divider with a 50 % duty cycle for both
// even and odd ratios. A posedge counter runs 0 .. D-1. A registered
// posedge waveform is high for the first floor(D/2) counts. For odd D, a
// negedge-retimed copy stretches the high phase by half a source cycle.
// Ratio changes and start/stop only take effect at period boundaries (the
// counter wrap), so the divided clock never produces runt pulses.
//
// Parameters
//   WIDTH        width of the divide ratio and the counter
//   DEFAULT_DIV  ratio in effect after reset (2 .. 2^WIDTH-1)
//
// Ports
//   clk       in   source clock
//   reset     in   asynchronous, active-high reset
//   en        in   run enable, sampled on posedge clk
//   div_in    in   requested divide ratio (0 and 1 are clamped to 2)
//   div_load  in   single-cycle strobe capturing div_in as the pending ratio
//   div_busy  out  a captured ratio is pending and not yet applied
//   div_cur   out  ratio currently in effect
//   clk_out   out  divided clock, period div_cur source cycles
//   tick      out  one-cycle pulse in the cycle where clk_out rises
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module clk_div_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic             div_busy,
   output logic [WIDTH-1:0] div_cur,
   output logic             clk_out,
   output logic             tick
);

   localparam logic [WIDTH-1:0] DEFAULT_W = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] MIN_DIV   = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] pend;
   logic             pos_q;
   logic             neg_q;

   logic [WIDTH-1:0] div_clamped;
   logic [WIDTH-1:0] div_last;
   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] half_cur;
   logic             wrap;

   // Ratios below 2 cannot produce a divided clock; force them to 2.
   assign div_clamped = (div_in < MIN_DIV) ? MIN_DIV : div_in;

   // div_cur is always >= 2, so div_cur-1 never underflows and cnt+1 is only
   // formed while cnt < div_cur-1 <= 2^WIDTH-2, so it never overflows.
   assign div_last = div_cur - ONE;
   assign wrap     = (cnt == div_last);
   assign cnt_inc  = cnt + ONE;
   assign half_cur = div_cur >> 1;

   //-------------------------------------------------------------------------
   // Control FSM, counter, posedge waveform, tick and ratio registers.
   // A period always starts with cnt = 0 and pos_q high (floor(D/2) >= 1).
   //-------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         pos_q    <= 1'b0;
         tick     <= 1'b0;
         div_cur  <= DEFAULT_W;
         pend     <= DEFAULT_W;
         div_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Nothing is being emitted, so a pending ratio can be applied
               // right away; if en is also high, the new period uses it.
               if (div_busy) begin
                  div_cur  <= pend;
                  div_busy <= 1'b0;
               end
               cnt <= '0;
               if (en) begin
                  state <= RUN;
                  pos_q <= 1'b1;
                  tick  <= 1'b1;
               end else begin
                  pos_q <= 1'b0;
                  tick  <= 1'b0;
               end
            end

            RUN: begin
               if (wrap) begin
                  // Period boundary: the only place ratio and run state change.
                  if (div_busy) begin
                     div_cur  <= pend;
                     div_busy <= 1'b0;
                  end
                  cnt <= '0;
                  if (en) begin
                     pos_q <= 1'b1;
                     tick  <= 1'b1;
                  end else begin
                     state <= IDLE;
                     pos_q <= 1'b0;
                     tick  <= 1'b0;
                  end
               end else begin
                  cnt   <= cnt_inc;
                  pos_q <= (cnt_inc < half_cur);
                  tick  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               cnt   <= '0;
               pos_q <= 1'b0;
               tick  <= 1'b0;
            end
         endcase

         // A load wins over the clear above: a load on the wrap edge stays
         // pending for one more full period, and back-to-back loads simply
         // overwrite the pending value.
         if (div_load) begin
            pend     <= div_clamped;
            div_busy <= 1'b1;
         end
      end
   end

   //-------------------------------------------------------------------------
   // Half-cycle delayed copy of pos_q, used to extend the high phase by half
   // a source cycle for odd ratios.
   //-------------------------------------------------------------------------
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         neg_q <= 1'b0;
      end else begin
         neg_q <= pos_q;
      end
   end

   // pos_q rises at a posedge while neg_q is already low, and pos_q falls a
   // half cycle before neg_q does, so the OR never glitches. div_cur only
   // changes at a wrap, where pos_q is rising and neg_q is low, so switching
   // the selection there is also clean. Reset clears both flops at once,
   // which drops clk_out without waiting for a clock edge.
   assign clk_out = div_cur[0] ? (pos_q | neg_q) : pos_q;

endmodule

// File: tb/tb_clk_div_prog.sv
//----------------------------------------------------------------------------
// tb_clk_div_prog
//
// Directed bench for clk_div_prog (WIDTH = 8, DEFAULT_DIV = 4). Expected
// values are queued as each stimulus step is driven and compared once the
// DUT has produced the corresponding output: cycle-level values are sampled
// 1 ns after the posedge, waveform high time and period are timed from
// clk_out edges.
//----------------------------------------------------------------------------
`timescale 1ns/100ps

module tb_clk_div_prog;

   localparam int WIDTH = 8;
   localparam int LIMIT = 3000;   // polling bound (ns) for any clk_out edge

   logic             clk;
   logic             reset;
   logic             en;
   logic [WIDTH-1:0] div_in;
   logic             div_load;
   logic             div_busy;
   logic [WIDTH-1:0] div_cur;
   logic             clk_out;
   logic             tick;

   clk_div_prog #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .div_in   (div_in),
      .div_load (div_load),
      .div_busy (div_busy),
      .div_cur  (div_cur),
      .clk_out  (clk_out),
      .tick     (tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef enum {K_CLK, K_TICK, K_BUSY, K_CUR, K_HIGH, K_PERIOD} kind_t;

   typedef struct {
      string tag;
      kind_t kind;
      int    val;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   meas_high;
   int   meas_period;

   task automatic expect_val(input string tag, input kind_t k, input int v);
      sb.push_back('{tag, k, v});
   endtask

   // Compare every queued expectation against what the DUT shows now.
   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            K_CLK:    obs = {31'b0, clk_out};
            K_TICK:   obs = {31'b0, tick};
            K_BUSY:   obs = {31'b0, div_busy};
            K_CUR:    obs = {24'b0, div_cur};
            K_HIGH:   obs = meas_high;
            default:  obs = meas_period;
         endcase
         checks++;
         assert (obs === e.val)
         else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick_cycle();
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic wait_level(input logic v, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < LIMIT; i++) begin
         if (clk_out === v) begin
            ok = 1'b1;
            break;
         end
         #1;
      end
   endtask

   // Time the next full clk_out period: low, rise (t0), fall (t1), rise (t2).
   // Polls sit half a ns off every clock edge, so no sample races an update.
   task automatic measure(input string tag, input int exp_period, input int exp_high);
      realtime t0, t1, t2;
      bit      ok;
      expect_val({tag, "_high"}, K_HIGH, exp_high);
      expect_val({tag, "_period"}, K_PERIOD, exp_period);
      meas_high   = -1;
      meas_period = -1;
      @(negedge clk);
      #0.5;
      wait_level(1'b0, ok);
      if (ok) begin
         wait_level(1'b1, ok);
         t0 = $realtime;
         if (ok) begin
            wait_level(1'b0, ok);
            t1 = $realtime;
            if (ok) begin
               meas_high = int'(t1 - t0);
               wait_level(1'b1, ok);
               t2 = $realtime;
               if (ok) meas_period = int'(t2 - t0);
            end
         end
      end
      drain();
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset    = 1'b0;
      en       = 1'b0;
      div_in   = '0;
      div_load = 1'b0;

      // ---- reset values, observed while reset is held ----
      #2 reset = 1'b1;
      #1;
      expect_val("rst_clk", K_CLK, 0);
      expect_val("rst_tick", K_TICK, 0);
      expect_val("rst_busy", K_BUSY, 0);
      expect_val("rst_cur", K_CUR, 4);
      drain();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // ---- default ratio 4: start latency, tick, edges ----
      en = 1'b1;
      expect_val("d4_clk_n0", K_CLK, 1);
      expect_val("d4_tick_n0", K_TICK, 1);
      expect_val("d4_cur", K_CUR, 4);
      tick_cycle();
      expect_val("d4_clk_n1", K_CLK, 1);
      expect_val("d4_tick_n1", K_TICK, 0);
      tick_cycle();
      expect_val("d4_clk_n2", K_CLK, 0);
      expect_val("d4_tick_n2", K_TICK, 0);
      tick_cycle();
      expect_val("d4_clk_n3", K_CLK, 0);
      tick_cycle();
      expect_val("d4_clk_n4", K_CLK, 1);
      expect_val("d4_tick_n4", K_TICK, 1);
      tick_cycle();
      measure("d4", 40, 20);

      // ---- odd ratio 5, loaded at cnt = 0 of a ratio-4 period ----
      div_in = 8'd5; div_load = 1'b1;
      expect_val("d5_busy_c1", K_BUSY, 1);
      expect_val("d5_cur_old", K_CUR, 4);
      tick_cycle();
      div_load = 1'b0;
      expect_val("d5_busy_c2", K_BUSY, 1);
      tick_cycle();
      expect_val("d5_busy_c3", K_BUSY, 1);
      expect_val("d5_cur_c3", K_CUR, 4);
      tick_cycle();
      expect_val("d5_cur_wrap", K_CUR, 5);
      expect_val("d5_busy_wrap", K_BUSY, 0);
      expect_val("d5_tick_wrap", K_TICK, 1);
      expect_val("d5_clk_wrap", K_CLK, 1);
      tick_cycle();
      measure("d5", 50, 25);

      // ---- back-to-back loads 6 then 3: last write wins ----
      div_in = 8'd6; div_load = 1'b1;
      expect_val("lw_busy_c1", K_BUSY, 1);
      expect_val("lw_cur_c1", K_CUR, 5);
      tick_cycle();
      div_in = 8'd3;
      expect_val("lw_busy_c2", K_BUSY, 1);
      tick_cycle();
      div_load = 1'b0;
      expect_val("lw_busy_c3", K_BUSY, 1);
      tick_cycle();
      expect_val("lw_busy_c4", K_BUSY, 1);
      expect_val("lw_cur_c4", K_CUR, 5);
      tick_cycle();
      expect_val("lw_cur_wrap", K_CUR, 3);
      expect_val("lw_busy_wrap", K_BUSY, 0);
      expect_val("lw_tick_wrap", K_TICK, 1);
      tick_cycle();
      measure("d3", 30, 15);

      // ---- load on the wrap edge: one more ratio-3 period first ----
      tick_cycle();                 // cnt = 1
      tick_cycle();                 // cnt = 2, next edge wraps
      div_in = 8'd7; div_load = 1'b1;
      expect_val("ww_tick_wrap1", K_TICK, 1);
      expect_val("ww_clk_wrap1", K_CLK, 1);
      expect_val("ww_busy_wrap1", K_BUSY, 1);
      expect_val("ww_cur_wrap1", K_CUR, 3);
      tick_cycle();
      div_load = 1'b0;
      expect_val("ww_busy_c1", K_BUSY, 1);
      tick_cycle();
      expect_val("ww_busy_c2", K_BUSY, 1);
      expect_val("ww_cur_c2", K_CUR, 3);
      tick_cycle();
      expect_val("ww_cur_wrap2", K_CUR, 7);
      expect_val("ww_busy_wrap2", K_BUSY, 0);
      expect_val("ww_tick_wrap2", K_TICK, 1);
      tick_cycle();
      measure("d7", 70, 35);

      // ---- clamp: 0 -> 2 ----
      div_in = 8'd0; div_load = 1'b1;
      expect_val("c0_busy", K_BUSY, 1);
      tick_cycle();
      div_load = 1'b0;
      for (int k = 2; k <= 6; k++) begin
         expect_val("c0_busy_wait", K_BUSY, 1);
         tick_cycle();
      end
      expect_val("c0_cur", K_CUR, 2);
      expect_val("c0_busy_wrap", K_BUSY, 0);
      expect_val("c0_tick_wrap", K_TICK, 1);
      tick_cycle();
      measure("c0", 20, 10);

      // ---- clamp: 1 -> 2 ----
      div_in = 8'd1; div_load = 1'b1;
      expect_val("c1_busy", K_BUSY, 1);
      tick_cycle();
      div_load = 1'b0;
      expect_val("c1_cur", K_CUR, 2);
      expect_val("c1_busy_wrap", K_BUSY, 0);
      expect_val("c1_tick_wrap", K_TICK, 1);
      tick_cycle();
      measure("c1", 20, 10);

      // ---- maximum ratio 255 ----
      div_in = 8'd255; div_load = 1'b1;
      expect_val("d255_busy", K_BUSY, 1);
      tick_cycle();
      div_load = 1'b0;
      expect_val("d255_cur", K_CUR, 255);
      expect_val("d255_tick", K_TICK, 1);
      tick_cycle();
      measure("d255", 2550, 1275);

      // ---- ratio 8, then en drops one cycle into the period ----
      div_in = 8'd8; div_load = 1'b1;
      tick_cycle();                 // cnt = 1
      div_load = 1'b0;
      for (int k = 2; k <= 253; k++) tick_cycle();
      expect_val("d8_busy_late", K_BUSY, 1);
      tick_cycle();                 // cnt = 254
      expect_val("d8_cur", K_CUR, 8);
      expect_val("d8_tick_n0", K_TICK, 1);
      expect_val("d8_clk_n0", K_CLK, 1);
      tick_cycle();                 // wrap: first ratio-8 period starts
      en = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         expect_val("stop_clk", K_CLK, (k < 4) ? 1 : 0);
         expect_val("stop_tick", K_TICK, 0);
         tick_cycle();
      end
      en = 1'b1;
      expect_val("restart_clk", K_CLK, 1);
      expect_val("restart_tick", K_TICK, 1);
      expect_val("restart_cur", K_CUR, 8);
      tick_cycle();
      measure("d8", 80, 40);

      // ---- asynchronous reset while clk_out is high, with a load pending ----
      div_in = 8'd3; div_load = 1'b1;
      expect_val("ar_busy_pre", K_BUSY, 1);
      expect_val("ar_clk_pre", K_CLK, 1);
      tick_cycle();
      div_load = 1'b0;
      #2 reset = 1'b1;
      #1;
      expect_val("ar_clk", K_CLK, 0);
      expect_val("ar_tick", K_TICK, 0);
      expect_val("ar_busy", K_BUSY, 0);
      expect_val("ar_cur", K_CUR, 4);
      drain();
      #2 reset = 1'b0;
      measure("ar_d4", 40, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
